sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 87 ++++++++
 tb/tb_sync_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. Synchronous active-high reset.
module sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       ren,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Status depends only on the count register, never on same-cycle requests.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  // NOTE: storage is deliberately left out of reset; after reset the pointers
  // make stale entries unreachable, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr] <= wdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rdata <= mem[rptr];
        rptr  <= rptr + AW'(1);
      end

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A fresh error outranks err_clr in the same cycle.
      if (wen && full)      overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;

      if (ren && empty)     underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model, scoreboard of
// expected read data, and a negedge monitor comparing data and status.
module tb_sync_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a plain queue, plus sticky flags.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last;
  logic              m_ovf;
  logic              m_unf;
  bit                mon_en;

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the model across the edge.
  task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d,
                      input logic rd, input logic ec);
    bit wr_ok, rd_ok;
    rst = r; wen = w; wdata = d; ren = rd; err_clr = ec;
    wr_ok = w && (mq.size() < DEPTH);
    rd_ok = rd && (mq.size() > 0);
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_last = '0;
    end else begin
      if (rd_ok) exp_q.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1;
      else if (ec)     m_ovf = 1'b0;
      if (rd && !rd_ok) m_unf = 1'b1;
      else if (ec)      m_unf = 1'b0;
    end
    #1;
  endtask

  // Monitor: one expected word per rvalid pulse; status against model occupancy.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rvalid", 32'(rvalid), 32'(exp_q.size() != 0));
      if (rvalid === 1'b1 && exp_q.size() != 0) begin
        m_last = exp_q.pop_front();
        check("rdata", 32'(rdata), 32'(m_last));
      end else begin
        check("rdata_hold", 32'(rdata), 32'(m_last));
      end
      check("count",        32'(count),        32'(mq.size()));
      check("full",         32'(full),         32'(mq.size() == DEPTH));
      check("empty",        32'(empty),        32'(mq.size() == 0));
      check("almost_full",  32'(almost_full),  32'(mq.size() >= AFULL_TH));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AEMPTY_TH));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
    end
  end

  initial begin
    int pw, pr;
    checks = 0; failures = 0; mon_en = 1'b0;
    m_last = '0; m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0; err_clr = 1'b0;

    // Reset with both requests active.
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_count",  32'(count), 32'd0);
    check("reset_empty",  32'(empty), 32'd1);
    check("reset_aempty", 32'(almost_empty), 32'd1);
    check("reset_full",   32'(full), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata",  32'(rdata), 32'd0);
    check("reset_errs",   32'({overflow, underflow}), 32'd0);

    // Fill 1..16, probing thresholds.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b0);
      if (i == 2 || i == 3 || i == 13 || i == 14 || i == 15 || i == 16) begin
        check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
        check("fill_afull",  32'(almost_full),  32'(i >= 14));
        check("fill_full",   32'(full),         32'(i == 16));
      end
    end
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag",  32'(overflow), 32'd1);

    // Drain 16 words in order.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_rdata",  32'(rdata), 32'(i));
      check("drain_rvalid", 32'(rvalid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_flag",   32'(underflow), 32'd1);
    check("unf_rvalid", 32'(rvalid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_errs", 32'({overflow, underflow}), 32'd0);

    // Steady simultaneous traffic across the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, DATA_W'(8'h45 + i), 1'b1, 1'b0);
      check("simul_count", 32'(count), 32'd5);
      check("simul_rdata", 32'(rdata), 32'(8'h40 + i));
    end
    check("simul_errs", 32'({overflow, underflow}), 32'd0);

    // Boundary simultaneity: full then empty.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, DATA_W'(8'h80 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_rw_count", 32'(count), 32'd15);
    check("full_rw_ovf",   32'(overflow), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    check("empty_rw_count",  32'(count), 32'd1);
    check("empty_rw_unf",    32'(underflow), 32'd1);
    check("empty_rw_rvalid", 32'(rvalid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("bnd_clr", 32'({overflow, underflow}), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("bnd_rdata", 32'(rdata), 32'h5A);

    // Reset mid-operation.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd7);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("mid_rst_rdata",  32'(rdata), 32'h3C);
    check("mid_rst_rvalid", 32'(rvalid), 32'd1);

    // Randomized traffic in phases biased toward full, empty and balanced.
    for (int i = 0; i < 2000; i++) begin
      case ((i / 250) % 4)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 90; end
      endcase
      step($urandom_range(199, 0) == 0,
           $urandom_range(99, 0) < pw,
           DATA_W'($urandom),
           $urandom_range(99, 0) < pr,
           $urandom_range(19, 0) == 0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
